// File: rtl/imem_port_arbiter_if.sv
// Fetch / load-store / memory bundle for the shared instruction-data memory arbiter.
// slave: arbiter side; master: requesters plus memory macro side.
interface imem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallF;
    logic        stallM;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output stallF, stallM
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  stallF, stallM
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory between fetch and LS.
// IMEM_ARB_FAIR_EN: bounds fetch starvation to STARVE_MAX consecutive LS grants.
module imem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1) begin : g_bad_cfg
        $error("imem_port_arbiter: illegal MEM_LAT or STARVE_MAX");
    end

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  lat_q, lat_d;
    logic        we_q, we_d;
    logic        kill_q, kill_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic done, grant_ok, force_if;
    logic if_win, ls_win, gnt_any;
    logic if_flight, kill_now;
    logic if_valid, ls_valid;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

`ifdef IMEM_ARB_FAIR_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_if = bus.if_req && (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (if_win || !bus.if_req) begin
            starve_d = '0;
        end else if (ls_win) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // A new grant may overlap the completion cycle of the current access.
    assign done     = (state_q == BUSY) && (lat_q == 3'd1);
    assign grant_ok = reset && ((state_q == IDLE) || done);
    assign ls_win   = grant_ok && bus.ls_req && !force_if;
    assign if_win   = grant_ok && bus.if_req && !ls_win;
    assign gnt_any  = if_win || ls_win;

    assign if_flight = (state_q == BUSY) && (owner_q == OWN_IF);
    assign kill_now  = kill_q || (bus.if_kill && if_flight);
    assign if_valid  = done && (owner_q == OWN_IF) && !kill_now;
    assign ls_valid  = done && (owner_q == OWN_LS);

    assign bus.if_gnt    = if_win;
    assign bus.ls_gnt    = ls_win;
    assign bus.mem_req   = gnt_any;
    assign bus.mem_we    = ls_win && bus.ls_we;
    assign bus.mem_be    = (ls_win && bus.ls_we) ? bus.ls_be : 4'hF;
    assign bus.mem_addr  = ls_win ? bus.ls_addr[31:2] : bus.if_addr[31:2];
    assign bus.mem_wdata = bus.ls_wdata;

    assign bus.if_rvalid = if_valid;
    assign bus.ls_rvalid = ls_valid;
    assign bus.if_rdata  = if_valid ? bus.mem_rdata : if_rdata_q;
    assign bus.ls_rdata  = (ls_valid && !we_q) ? bus.mem_rdata : ls_rdata_q;

    assign bus.stallF = bus.if_req && !if_win;
    assign bus.stallM = bus.ls_req && !ls_win;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        we_d       = we_q;
        kill_d     = kill_now;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        unique case (state_q)
            IDLE: ;
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    lat_d   = '0;
                    owner_d = OWN_NONE;
                    we_d    = 1'b0;
                    kill_d  = 1'b0;
                    if (if_valid) begin
                        if_rdata_d = bus.mem_rdata;
                    end
                    if (ls_valid && !we_q) begin
                        ls_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: ;
        endcase
        if (gnt_any) begin
            state_d = BUSY;
            lat_d   = LAT;
            owner_d = ls_win ? OWN_LS : OWN_IF;
            we_d    = ls_win && bus.ls_we;
            kill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_q    <= OWN_NONE;
            we_q       <= 1'b0;
            kill_q     <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            kill_q     <= kill_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios then random traffic, checked
// against a transaction-queue reference model and an independent memory model.
module tb_imem_port_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    typedef struct {
        int          due;
        bit          is_if;
        bit          st;
        logic [31:0] data;
        bit          killed;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_port_arbiter_if bus();

    imem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int starve = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_ls = '0;
    txn_t q[$];
    logic [31:0] dmem [int];
    logic [31:0] rmem [int];
    logic [31:0] pipe [LAT];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rword(input int w);
        return rmem.exists(w) ? rmem[w] : 32'(w);
    endfunction

    function automatic logic [31:0] dword(input int w);
        return dmem.exists(w) ? dmem[w] : 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle();
        bit comp, allow, frc, e_if, e_ls, kill, e_ifv, e_lsv, e_we;
        logic [31:0] e_ifd, e_lsd, rdv;
        logic [3:0]  e_be;
        int w;
        txn_t t;
        logic m_req, m_we;
        logic [29:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wd;
        #1;
        if (!reset) begin
            q.delete();
            last_if = '0;
            last_ls = '0;
            starve  = 0;
        end
        comp  = reset && q.size() > 0 && q[0].due == cyc;
        allow = reset && (q.size() == 0 || comp);
        frc   = 1'b0;
`ifdef IMEM_ARB_FAIR_EN
        frc = bus.if_req && starve == SMAX;
`endif
        e_ls  = allow && bus.ls_req && !frc;
        e_if  = allow && bus.if_req && !e_ls;
        e_we  = e_ls && bus.ls_we;
        e_be  = e_we ? bus.ls_be : 4'hF;
        kill  = reset && bus.if_kill && q.size() > 0 && q[0].is_if;
        e_ifv = comp && q[0].is_if && !(q[0].killed || kill);
        e_lsv = comp && !q[0].is_if;
        e_ifd = e_ifv ? q[0].data : last_if;
        e_lsd = (e_lsv && !q[0].st) ? q[0].data : last_ls;

        chk("if_gnt",    32'(bus.if_gnt),    32'(e_if));
        chk("ls_gnt",    32'(bus.ls_gnt),    32'(e_ls));
        chk("mem_req",   32'(bus.mem_req),   32'(e_if || e_ls));
        chk("mem_we",    32'(bus.mem_we),    32'(e_we));
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
        chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(e_lsv));
        chk("if_rdata",  bus.if_rdata,       e_ifd);
        chk("ls_rdata",  bus.ls_rdata,       e_lsd);
        chk("stallF",    32'(bus.stallF),    32'(bus.if_req && !e_if));
        chk("stallM",    32'(bus.stallM),    32'(bus.ls_req && !e_ls));
        w = 0;
        if (e_if || e_ls) begin
            w = e_ls ? int'(bus.ls_addr[31:2]) : int'(bus.if_addr[31:2]);
            chk("mem_addr", 32'(bus.mem_addr), 32'(w));
            chk("mem_be",   32'(bus.mem_be),   32'(e_be));
            if (e_we) chk("mem_wdata", bus.mem_wdata, bus.ls_wdata);
        end

        m_req  = bus.mem_req;
        m_we   = bus.mem_we;
        m_addr = bus.mem_addr;
        m_be   = bus.mem_be;
        m_wd   = bus.mem_wdata;

        if (kill) q[0].killed = 1'b1;
        if (comp) begin
            if (e_ifv) last_if = q[0].data;
            if (e_lsv && !q[0].st) last_ls = q[0].data;
            void'(q.pop_front());
        end
        if (e_if || e_ls) begin
            t.due    = cyc + LAT;
            t.is_if  = e_if;
            t.st     = e_we;
            t.killed = 1'b0;
            t.data   = rword(w);
            if (e_we) rmem[w] = merge(rword(w), bus.ls_wdata, bus.ls_be);
            q.push_back(t);
        end
        if (e_if || !bus.if_req) starve = 0;
        else if (e_ls) starve++;

        @(posedge clk);
        cyc++;
        #1;
        rdv = $urandom;
        if (m_req) begin
            rdv = dword(int'(m_addr));
            if (m_we) dmem[int'(m_addr)] = merge(rdv, m_wd, m_be);
        end
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = rdv;
        bus.mem_rdata = pipe[LAT-1];
        if (e_if) bus.if_req = 1'b0;
        if (e_ls) bus.ls_req = 1'b0;
        bus.if_kill = 1'b0;
    endtask

    task automatic req_if(input logic [31:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
    endtask

    task automatic req_ls(input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] d);
        bus.ls_req   = 1'b1;
        bus.ls_we    = we;
        bus.ls_be    = be;
        bus.ls_addr  = a;
        bus.ls_wdata = d;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((bus.if_req || bus.ls_req || q.size() > 0) && k < 40) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(k < 40), 32'd1);
    endtask

    initial begin
        reset         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_kill   = 1'b0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = '0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        // reset: requests present but nothing granted
        req_if(32'h8000);
        cycle();
        cycle();
        reset = 1'b1;

        // fetch-only stream
        cycle();
        req_if(32'h8004);
        drain();

        // LS beats IF
        req_if(32'h8008);
        req_ls(1'b0, 4'h0, 32'h100, 32'h0);
        drain();

        // kill of an in-flight fetch, LS grant in the completion cycle
        req_if(32'h800C);
        cycle();
        bus.if_kill = 1'b1;
        cycle();
        cycle();
        req_ls(1'b0, 4'h0, 32'h104, 32'h0);
        drain();

        // partial store then readback
        req_ls(1'b1, 4'b0011, 32'h104, 32'hDEADBEEF);
        drain();
        req_ls(1'b0, 4'h0, 32'h104, 32'h0);
        drain();

        // both ports held busy: fairness behaviour
        for (int k = 0; k < 60; k++) begin
            if (!bus.if_req) req_if(32'h8000 + 32'(k) * 4);
            if (!bus.ls_req) req_ls(1'b0, 4'h0, 32'h100 + 32'(k % 8) * 4, 32'h0);
            cycle();
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        drain();

        // reset in the middle of a busy access
        req_if(32'h8010);
        cycle();
        cycle();
        reset = 1'b0;
        req_if(32'h8014);
        cycle();
        cycle();
        reset = 1'b1;
        drain();

        // random traffic
        for (int k = 0; k < 800; k++) begin
            if (!bus.if_req && $urandom_range(0, 99) < 60)
                req_if(32'h8000 + 32'($urandom_range(0, 15)) * 4);
            if (!bus.ls_req && $urandom_range(0, 99) < 45)
                req_ls(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
            bus.if_kill = ($urandom_range(0, 99) < 12);
            cycle();
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
